// File: rtl/key_pkg.sv
// Shared types and elaboration helpers for the multi-channel key conditioner.
package key_pkg;

  // Per-channel debounce / hold state
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PCHK = 3'd1,
    S_HELD = 3'd2,
    S_RPT  = 3'd3,
    S_RCHK = 3'd4
  } key_state_t;

  // Bits needed for a counter that must be able to hold the largest interval
  function automatic int unsigned cnt_width_req(input int unsigned deb,
                                                input int unsigned long_c,
                                                input int unsigned rpt);
    int unsigned m;
    m = deb;
    if (long_c > m) m = long_c;
    if (rpt > m) m = rpt;
    return $clog2(m + 1);
  endfunction

  // Parameter sanity: debounce needs at least two samples, intervals non-zero,
  // and the counter must be wide enough for every interval
  function automatic bit params_ok(input int unsigned deb,
                                   input int unsigned long_c,
                                   input int unsigned rpt,
                                   input int unsigned cnt_w);
    return (deb >= 2) && (long_c >= 1) && (rpt >= 1) &&
           (cnt_w >= cnt_width_req(deb, long_c, rpt));
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce/hold FSM, saturating counter,
// registered level and single-cycle event pulses.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned DEB_CYCLES    = 1000000,
  parameter int unsigned LONG_CYCLES   = 50000000,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned REPEAT_CYCLES = 10000000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  // The counter is compared against "interval - 1" because the sample that
  // completes an interval is the one that fires the registered pulse.
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic             KEY_IDLE  = ACTIVE_LOW;

  logic             r_sync1, r_sync2;
  key_state_t       r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic             r_long_seen, w_long_seen_next;
  logic             r_level, w_level_next;
  logic             r_press, w_press_next;
  logic             r_release, w_release_next;
  logic             r_long, w_long_next;
  logic             r_repeat, w_repeat_next;
  logic             w_k;

  // Two-stage synchroniser; resets to the released pin level so no edge is seen
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= KEY_IDLE;
      r_sync2 <= KEY_IDLE;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  assign w_k       = ACTIVE_LOW ? ~r_sync2 : r_sync2;
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  // FSM, counter and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_long_seen <= 1'b0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
      r_repeat    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_long_seen <= w_long_seen_next;
      r_level     <= w_level_next;
      r_press     <= w_press_next;
      r_release   <= w_release_next;
      r_long      <= w_long_next;
      r_repeat    <= w_repeat_next;
    end
  end

  // Next-state and next-output decode; pulses default low so each lasts one cycle
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_long_seen_next = r_long_seen;
    w_level_next     = r_level;
    w_press_next     = 1'b0;
    w_release_next   = 1'b0;
    w_long_next      = 1'b0;
    w_repeat_next    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_level_next = 1'b0;
        w_cnt_next   = '0;
        if (w_k) begin
          w_state_next = S_PCHK;
          w_cnt_next   = CNT_W'(1);
        end
      end
      S_PCHK: begin
        if (!w_k) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next = S_HELD;
          w_level_next = 1'b1;
          w_press_next = 1'b1;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_HELD: begin
        if (!w_k) begin
          w_state_next     = S_RCHK;
          w_cnt_next       = CNT_W'(1);
          w_long_seen_next = 1'b0;
        end else if (r_cnt == LONG_LAST) begin
          w_state_next = S_RPT;
          w_long_next  = 1'b1;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_RPT: begin
        if (!w_k) begin
          w_state_next     = S_RCHK;
          w_cnt_next       = CNT_W'(1);
          w_long_seen_next = 1'b1;
        end else if (REPEAT_EN && (r_cnt == RPT_LAST)) begin
          w_repeat_next = 1'b1;
          w_cnt_next    = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_RCHK: begin
        if (w_k) begin
          // Release glitch absorbed: resume where the hold left off, timer restarted
          w_state_next = r_long_seen ? S_RPT : S_HELD;
          w_cnt_next   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next   = S_IDLE;
          w_level_next   = 1'b0;
          w_release_next = 1'b1;
          w_cnt_next     = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
        w_level_next = 1'b0;
      end
    endcase
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: one independent key_debounce_ch per pin.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned DEB_CYCLES    = 1000000,
  parameter int unsigned LONG_CYCLES   = 50000000,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned REPEAT_CYCLES = 10000000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_keys,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_long,
  output logic [N_CH-1:0] o_repeat
);

  localparam bit PARAMS_OK = params_ok(DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES, CNT_W);

  // Refuse to elaborate with a debounce interval under 2 or a too-narrow counter
  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("key_debounce_multi: DEB_CYCLES must be >= 2 and CNT_W must hold every interval");
    end
  endgenerate

  // One channel per key; the top only slices the buses
  generate
    for (genvar gi = 0; gi < int'(N_CH); gi++) begin : g_ch
      key_debounce_ch #(
        .ACTIVE_LOW   (ACTIVE_LOW),
        .DEB_CYCLES   (DEB_CYCLES),
        .LONG_CYCLES  (LONG_CYCLES),
        .REPEAT_EN    (REPEAT_EN),
        .REPEAT_CYCLES(REPEAT_CYCLES),
        .CNT_W        (CNT_W)
      ) u_ch (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_key    (i_keys[gi]),
        .o_level  (o_level[gi]),
        .o_press  (o_press[gi]),
        .o_release(o_release[gi]),
        .o_long   (o_long[gi]),
        .o_repeat (o_repeat[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: expected pulses are scheduled on a scoreboard
// when stimulus is applied and matched against every pulse the DUT produces.
module tb_key_debounce_multi;

  localparam int N_CH  = 4;
  localparam int DEB   = 4;
  localparam int LONG  = 20;
  localparam int RPT   = 8;
  localparam int CNT_W = 8;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;
  localparam int K_REPEAT  = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N_CH-1:0] keys = '1;
  logic [N_CH-1:0] o_level, o_press, o_release, o_long, o_repeat;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;

  key_debounce_multi #(
    .N_CH         (N_CH),
    .ACTIVE_LOW   (1'b1),
    .DEB_CYCLES   (DEB),
    .LONG_CYCLES  (LONG),
    .REPEAT_EN    (1'b1),
    .REPEAT_CYCLES(RPT),
    .CNT_W        (CNT_W)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_keys   (keys),
    .o_level  (o_level),
    .o_press  (o_press),
    .o_release(o_release),
    .o_long   (o_long),
    .o_repeat (o_repeat)
  );

  always #5 clk = ~clk;

  function automatic string kind_name(input int k);
    case (k)
      K_PRESS:   return "press";
      K_RELEASE: return "release";
      K_LONG:    return "long";
      default:   return "repeat";
    endcase
  endfunction

  // Schedule a pulse expected in the cycle following edge number 'at'
  task automatic expect_pulse(input int at, input int ch, input int kind);
    exp_t e;
    e.cyc  = at;
    e.ch   = ch;
    e.kind = kind;
    sb.push_back(e);
  endtask

  // Advance one clock; at the following falling edge pop every observed pulse
  // off the scoreboard and flag anything unexpected or overdue.
  task automatic step();
    logic [N_CH-1:0] obs [4];
    bit found;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    obs[0] = o_press;
    obs[1] = o_release;
    obs[2] = o_long;
    obs[3] = o_repeat;
    for (int k = 0; k < 4; k++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (obs[k][ch] !== 1'b0) begin
          found = 1'b0;
          for (int i = 0; i < sb.size(); i++) begin
            if (!found && sb[i].cyc == cyc && sb[i].ch == ch && sb[i].kind == k) begin
              sb.delete(i);
              found = 1'b1;
            end
          end
          vectors++;
          if (!found) begin
            errors++;
            $display("FAIL unexpected_%s cyc=%0d ch=%0d: got %b, required 0",
                     kind_name(k), cyc, ch, obs[k][ch]);
          end else begin
            $display("cyc=%0d ch=%0d %s pulse matched", cyc, ch, kind_name(k));
          end
        end
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        vectors++;
        errors++;
        $display("FAIL missed_%s ch=%0d: got no pulse at cyc=%0d, required one",
                 kind_name(sb[i].kind), sb[i].ch, sb[i].cyc);
        sb.delete(i);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    vectors++;
    if ({o_level, o_press, o_release, o_long, o_repeat} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0",
               {o_level, o_press, o_release, o_long, o_repeat});
    end
    rst_n = 1'b1;
    repeat (8) step();
    vectors++;
    if (o_level !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_level: got %b, required 0000", o_level);
    end
  endtask

  task automatic test_clean_press();
    int e;
    keys[0] = 1'b0;
    e = cyc + 1;
    expect_pulse(e + 5, 0, K_PRESS);
    repeat (9) begin
      step();
      vectors++;
      if (o_level !== ((cyc >= e + 5) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL clean_press_level cyc=%0d: got %b, required %b", cyc, o_level,
                 (cyc >= e + 5) ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  // Channel 0 is held from the previous test
  task automatic test_release_glitch();
    int c, e;
    c = cyc;
    keys[0] = 1'b1;
    step();
    step();
    keys[0] = 1'b0;
    expect_pulse(c + 25, 0, K_LONG);
    while (cyc < c + 28) begin
      step();
      vectors++;
      if (o_level[0] !== 1'b1) begin
        errors++;
        $display("FAIL glitch_level cyc=%0d: got %b, required 1", cyc, o_level[0]);
      end
    end
    keys[0] = 1'b1;
    e = cyc + 1;
    expect_pulse(e + 5, 0, K_RELEASE);
    while (cyc < e + 7) step();
    vectors++;
    if (o_level[0] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_final_level: got %b, required 0", o_level[0]);
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    pat = 6'b100100;  // applied LSB first: 0,0,1,0,0,1
    for (int i = 0; i < 6; i++) begin
      keys[1] = pat[i];
      step();
    end
    keys[1] = 1'b1;
    repeat (10) begin
      step();
      vectors++;
      if (o_level[1] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_level cyc=%0d: got %b, required 0", cyc, o_level[1]);
      end
    end
  endtask

  task automatic test_long_repeat();
    int e, p, r;
    keys[2] = 1'b0;
    e = cyc + 1;
    p = e + 5;
    expect_pulse(p, 2, K_PRESS);
    expect_pulse(p + LONG, 2, K_LONG);
    for (int n = 1; n <= 5; n++) expect_pulse(p + LONG + n * RPT, 2, K_REPEAT);
    while (cyc < p + 60) step();
    vectors++;
    if (o_level !== 4'b0100) begin
      errors++;
      $display("FAIL long_hold_level: got %b, required 0100", o_level);
    end
    keys[2] = 1'b1;
    r = cyc + 1;
    expect_pulse(r + 5, 2, K_RELEASE);
    while (cyc < r + 7) step();
    vectors++;
    if (o_level !== 4'b0000) begin
      errors++;
      $display("FAIL long_release_level: got %b, required 0000", o_level);
    end
  endtask

  task automatic test_concurrency();
    int e, p;
    keys[0] = 1'b0;
    keys[3] = 1'b0;
    e = cyc + 1;
    p = e + 5;
    expect_pulse(p, 0, K_PRESS);
    expect_pulse(p, 3, K_PRESS);
    expect_pulse(p + LONG, 0, K_LONG);
    expect_pulse(p + LONG, 3, K_LONG);
    while (cyc < p) step();
    vectors++;
    if (o_press !== 4'b1001) begin
      errors++;
      $display("FAIL concurrent_press: got %b, required 1001", o_press);
    end
    while (cyc < p + LONG) step();
  endtask

  // Entered with channels 0 and 3 just moved into the repeat phase
  task automatic test_reset_mid_hold();
    int e, r;
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_before_reset: got %0d entries, required 0", sb.size());
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({o_level, o_press, o_release, o_long, o_repeat} !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h, required 0",
               {o_level, o_press, o_release, o_long, o_repeat});
    end
    repeat (3) step();
    rst_n = 1'b1;
    e = cyc + 1;
    expect_pulse(e + 5, 0, K_PRESS);
    expect_pulse(e + 5, 3, K_PRESS);
    while (cyc < e + 8) step();
    vectors++;
    if (o_level !== 4'b1001) begin
      errors++;
      $display("FAIL reset_repress_level: got %b, required 1001", o_level);
    end
    keys[0] = 1'b1;
    keys[3] = 1'b1;
    r = cyc + 1;
    expect_pulse(r + 5, 0, K_RELEASE);
    expect_pulse(r + 5, 3, K_RELEASE);
    while (cyc < r + 8) step();
    vectors++;
    if (sb.size() != 0 || o_level !== 4'b0000) begin
      errors++;
      $display("FAIL final_state: got %0d pending / level %b, required 0 / 0000",
               sb.size(), o_level);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release_glitch();
    test_bounce();
    test_long_repeat();
    test_concurrency();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
